serial_mult_seq: RTL and testbench
==================================

Name: serial_mult_seq

Overview:
- Parametrised bit-serial multiplier. Two operands of WIDTH bits each arrive serially, LSB first, under a valid strobe. The block forms the full 2*WIDTH-bit product in either unsigned or two's-complement mode, then shifts it out serially, LSB first, with valid and last framing.
- It is the framed, stallable, parametrised successor to the fixed 4-bit serial multiplier top. It sits between a serial link front-end and a serial result consumer.

Parameters:
- WIDTH, 4: operand width in bits; legal range 2..16; the product is 2*WIDTH bits.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- IN_VALID  in  1  the A/B bits on this cycle are valid; sampled only in IDLE and LOAD.
- A  in  1  serial multiplicand bit, LSB first.
- B  in  1  serial multiplier bit, LSB first.
- SIGNED  in  1  1 = two's-complement, 0 = unsigned; sampled together with operand bit 0 and held for the whole frame.
- BUSY  out  1  high whenever the state is not IDLE (combinational from the state).
- O  out  1  serial product bit, LSB first; registered.
- O_VALID  out  1  O carries a product bit; registered.
- O_LAST  out  1  O carries product bit 2*WIDTH-1; registered.

Behaviour:
- Reset (RST=1 at an edge) forces:
  - state = IDLE;
  - all counters, operand registers and the accumulator = 0;
  - O = 0, O_VALID = 0, O_LAST = 0.
  - This holds from any state, including mid-frame. The partial frame is discarded and no output bits follow it.
- States and transitions:
  - IDLE: BUSY = 0. When IN_VALID = 1 at an edge: capture A, B and SIGNED as bit 0, set in_cnt = 1, go to LOAD.
  - LOAD: each edge with IN_VALID = 1 captures the next bit at index in_cnt and increments in_cnt.
    - IN_VALID = 0 is a stall: hold in_cnt and the operands; no timeout.
    - The edge that captures bit WIDTH-1 goes to CALC with calc_cnt = 0.
  - CALC: exactly WIDTH cycles, one shift-add step per cycle, independent of the input pins. IN_VALID is ignored. After the WIDTH-th step go to SEND with out_cnt = 0.
  - SEND: exactly 2*WIDTH cycles. Each edge registers O = product[out_cnt] and O_VALID = 1, then increments out_cnt.
    - O_LAST = 1 is registered together with bit 2*WIDTH-1.
    - The same edge returns the state to IDLE.
    - IN_VALID is ignored throughout SEND.
- Output timing:
  - Let e0 be the edge that samples the last operand bit.
  - O_VALID first reads high after edge e0+WIDTH+1.
  - O_VALID stays high for exactly 2*WIDTH consecutive cycles.
  - O, O_VALID and O_LAST return to 0 on the edge after the O_LAST cycle.
- Back-to-back frames: the state is IDLE during the O_LAST cycle. An IN_VALID bit presented in that cycle is accepted as bit 0 of the next frame.
- Arithmetic:
  - Unsigned: product = A*B, 2*WIDTH bits, exact.
  - Signed: both operands are two's-complement; product is the exact signed 2*WIDTH-bit result. WIDTH-bit operands cannot overflow 2*WIDTH bits; -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2) is representable.
  - The accumulator is at least 2*WIDTH bits wide; no truncation and no saturation.
- Counters:
  - in_cnt and calc_cnt are clog2(WIDTH) bits; out_cnt is clog2(2*WIDTH) bits.
  - No counter may wrap within a frame.
  - Terminal counts are compared explicitly; behaviour must not rely on natural power-of-two rollover, so non-power-of-2 WIDTH works.
- Idle outputs: O must be 0 whenever O_VALID = 0.

Test Plan:
- WIDTH=4, SIGNED=0, A=1111, B=1111 (15*15) -> O bits LSB first 1,0,0,0,0,1,1,1 (0xE1 = 225); O_VALID high 8 cycles, rising WIDTH+1 = 5 cycles after the last input bit; O_LAST on the 8th bit.
- WIDTH=4, SIGNED=1: A=0111, B=1000 (7 * -8) -> 0xC8 (-56), LSB first 0,0,0,1,0,0,1,1. Also A=1111, B=1111 (-1 * -1) -> 0x01. Also A=1000, B=1000 -> 0x40.
- WIDTH=4 stall: operand bits delivered with IN_VALID gaps of 1, 3 and 0 cycles -> same product as an unstalled frame; BUSY high from after bit 0 until the state returns to IDLE.
- IN_VALID toggling during CALC and SEND -> no effect on the result. Then a new frame starting in the O_LAST cycle -> second product correct; O_VALID gap of exactly WIDTH+4 cycles between frames.
- RST=1 during the 3rd SEND bit -> next edge O = O_VALID = O_LAST = BUSY = 0; the next frame (3*5) yields 0x0F.
- WIDTH=8, SIGNED=0, 255*255 -> 0xFE01 over 16 bits. WIDTH=5 (non-power-of-2), SIGNED=1, -16 * -16 -> 0x100 over 10 bits.

Source files
------------

// File: rtl/serial_mult_seq.sv
// serial_mult_seq: bit-serial WIDTH x WIDTH multiplier, unsigned or two's-complement, framed serial output
// Ports: CLK/RST (sync active-high reset), IN_VALID/A/B/SIGNED serial operand input (LSB first),
//        BUSY (state not IDLE), O/O_VALID/O_LAST registered serial product output (LSB first).
module serial_mult_seq #(
   parameter int WIDTH = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic IN_VALID,
   input  logic A,
   input  logic B,
   input  logic SIGNED,
   output logic BUSY,
   output logic O,
   output logic O_VALID,
   output logic O_LAST
);
   localparam int CW = $clog2(WIDTH);
   localparam int OW = $clog2(2 * WIDTH);
   typedef enum logic [1:0] {IDLE, LOAD, CALC, SEND} state_t;
   state_t state;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic sgn;
   logic [CW-1:0] in_cnt, calc_cnt;
   logic [OW-1:0] out_cnt;
   logic [2*WIDTH-1:0] acc, ext, part, term;
   assign BUSY = state != IDLE;
   // The MSB of B carries weight -2^(WIDTH-1) in signed mode, so that step subtracts.
   always_comb begin
      ext  = {{WIDTH{sgn & a_reg[WIDTH-1]}}, a_reg};
      part = b_reg[calc_cnt] ? ext << calc_cnt : '0;
      term = (sgn && calc_cnt == CW'(WIDTH - 1)) ? -part : part;
   end
   // Operands shift in from the MSB end so bit 0 lands at index 0 after WIDTH captures.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         sgn      <= 1'b0;
         in_cnt   <= '0;
         calc_cnt <= '0;
         out_cnt  <= '0;
         acc      <= '0;
         O        <= 1'b0;
         O_VALID  <= 1'b0;
         O_LAST   <= 1'b0;
      end else begin
         O       <= 1'b0;
         O_VALID <= 1'b0;
         O_LAST  <= 1'b0;
         case (state)
            IDLE: if (IN_VALID) begin
               a_reg  <= {A, a_reg[WIDTH-1:1]};
               b_reg  <= {B, b_reg[WIDTH-1:1]};
               sgn    <= SIGNED;
               in_cnt <= CW'(1);
               acc    <= '0;
               state  <= LOAD;
            end
            LOAD: if (IN_VALID) begin
               a_reg <= {A, a_reg[WIDTH-1:1]};
               b_reg <= {B, b_reg[WIDTH-1:1]};
               if (in_cnt == CW'(WIDTH - 1)) begin
                  state    <= CALC;
                  calc_cnt <= '0;
               end else in_cnt <= in_cnt + CW'(1);
            end
            CALC: begin
               acc <= acc + term;
               if (calc_cnt == CW'(WIDTH - 1)) begin
                  state   <= SEND;
                  out_cnt <= '0;
               end else calc_cnt <= calc_cnt + CW'(1);
            end
            SEND: begin
               O       <= acc[out_cnt];
               O_VALID <= 1'b1;
               O_LAST  <= out_cnt == OW'(2 * WIDTH - 1);
               if (out_cnt == OW'(2 * WIDTH - 1)) state <= IDLE;
               else out_cnt <= out_cnt + OW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_mult_seq.sv
// tb_serial_mult_seq: directed and randomized checks of serial_mult_seq at WIDTH 4, 8 and 5
module tb_serial_mult_seq;
   logic CLK = 1'b0, RST = 1'b1, A = 1'b0, B = 1'b0, SIGNED = 1'b0;
   logic [2:0] iv = '0;
   logic [2:0] busy, o, ov, ol;
   int checks = 0, errors = 0, cyc = 0, e0 = 0, last_cyc = 0, first_cyc = 0, l1 = 0, n = 0;
   int gap[16];
   logic [15:0] ra, rb;
   bit rs, rn;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   serial_mult_seq #(.WIDTH(4)) u4 (.CLK(CLK), .RST(RST), .IN_VALID(iv[0]), .A(A), .B(B), .SIGNED(SIGNED),
      .BUSY(busy[0]), .O(o[0]), .O_VALID(ov[0]), .O_LAST(ol[0]));
   serial_mult_seq #(.WIDTH(8)) u8 (.CLK(CLK), .RST(RST), .IN_VALID(iv[1]), .A(A), .B(B), .SIGNED(SIGNED),
      .BUSY(busy[1]), .O(o[1]), .O_VALID(ov[1]), .O_LAST(ol[1]));
   serial_mult_seq #(.WIDTH(5)) u5 (.CLK(CLK), .RST(RST), .IN_VALID(iv[2]), .A(A), .B(B), .SIGNED(SIGNED),
      .BUSY(busy[2]), .O(o[2]), .O_VALID(ov[2]), .O_LAST(ol[2]));

   function automatic int wd(int k);
      return k == 0 ? 4 : k == 1 ? 8 : 5;
   endfunction

   // Exact product from integer arithmetic, truncated to the 2*w-bit frame.
   function automatic logic [31:0] model(int w, logic [15:0] a, logic [15:0] b, bit s);
      longint x, y, m;
      x = longint'(a) & ((longint'(1) << w) - 1);
      y = longint'(b) & ((longint'(1) << w) - 1);
      m = (longint'(1) << (2 * w)) - 1;
      if (s && x[w-1]) x = x - (longint'(1) << w);
      if (s && y[w-1]) y = y - (longint'(1) << w);
      return 32'((x * y) & m);
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(int k, logic [15:0] a, logic [15:0] b, bit s);
      int w = wd(k);
      chk("idle_busy", busy[k], 0);
      for (int i = 0; i < w; i++) begin
         for (int g = 0; i > 0 && g < gap[i]; g++) begin
            iv[k] = 1'b0;
            A = 1'($urandom);
            B = 1'($urandom);
            step();
            chk("stall_busy", busy[k], 1);
         end
         iv[k] = 1'b1;
         A = a[i];
         B = b[i];
         SIGNED = s;
         step();
         chk("load_busy", busy[k], 1);
      end
      iv[k] = 1'b0;
      e0 = cyc;
   endtask

   // Returns positioned in the O_LAST cycle so a caller may start the next frame there.
   task automatic recv(int k, logic [31:0] exp, bit noise);
      int w = wd(k), m = 0;
      while (!ov[k] && m < 200) begin
         if (noise) begin
            iv[k] = 1'($urandom);
            A = 1'($urandom);
            B = 1'($urandom);
         end
         step();
         m++;
      end
      chk("latency", 64'(cyc - e0), 64'(w + 1));
      if (!ov[k]) return;
      first_cyc = cyc;
      for (int i = 0; i < 2 * w; i++) begin
         chk("o_valid", ov[k], 1);
         chk("o_bit", o[k], exp[i]);
         chk("o_last", ol[k], i == 2 * w - 1);
         if (i == 2 * w - 1) begin
            iv[k] = 1'b0;
            last_cyc = cyc;
            chk("last_idle", busy[k], 0);
         end else begin
            if (noise) begin
               iv[k] = 1'($urandom);
               A = 1'($urandom);
               B = 1'($urandom);
            end
            step();
         end
      end
   endtask

   task automatic tail(int k);
      step();
      chk("tail_valid", ov[k], 0);
      chk("tail_o", o[k], 0);
      chk("tail_last", ol[k], 0);
      chk("tail_busy", busy[k], 0);
   endtask

   task automatic frame(int k, logic [15:0] a, logic [15:0] b, bit s, logic [31:0] exp, bit noise);
      send(k, a, b, s);
      recv(k, exp, noise);
      tail(k);
   endtask

   initial begin
      foreach (gap[i]) gap[i] = 0;
      step();
      step();
      RST = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_busy", busy[k], 0);
         chk("rst_o", o[k], 0);
         chk("rst_valid", ov[k], 0);
         chk("rst_last", ol[k], 0);
      end
      frame(0, 16'hF, 16'hF, 1'b0, 32'hE1, 1'b0);
      frame(0, 16'h7, 16'h8, 1'b1, 32'hC8, 1'b0);
      frame(0, 16'hF, 16'hF, 1'b1, 32'h01, 1'b0);
      frame(0, 16'h8, 16'h8, 1'b1, 32'h40, 1'b0);
      gap[1] = 1;
      gap[2] = 3;
      gap[3] = 0;
      frame(0, 16'h6, 16'hB, 1'b0, 32'h42, 1'b0);
      gap[1] = 0;
      gap[2] = 0;
      send(0, 16'h9, 16'hD, 1'b0);
      recv(0, 32'h75, 1'b1);
      l1 = last_cyc;
      send(0, 16'h5, 16'h3, 1'b1);
      recv(0, 32'h0F, 1'b0);
      chk("b2b_gap", 64'(first_cyc - l1 - 1), 64'(4 + 4));
      tail(0);
      send(0, 16'h3, 16'h5, 1'b0);
      n = 0;
      while (!ov[0] && n < 50) begin
         step();
         n++;
      end
      chk("rst_wait", ov[0], 1);
      step();
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("mid_rst_o", o[0], 0);
      chk("mid_rst_valid", ov[0], 0);
      chk("mid_rst_last", ol[0], 0);
      chk("mid_rst_busy", busy[0], 0);
      step();
      chk("mid_rst_quiet", ov[0], 0);
      frame(0, 16'h3, 16'h5, 1'b0, 32'h0F, 1'b0);
      frame(1, 16'hFF, 16'hFF, 1'b0, 32'hFE01, 1'b0);
      frame(2, 16'h10, 16'h10, 1'b1, 32'h100, 1'b0);
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 8; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rn = 1'($urandom);
            foreach (gap[i]) gap[i] = $urandom_range(0, 2);
            frame(k, ra, rb, rs, model(wd(k), ra, rb, rs), rn);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
